push_rr_arbiter: RTL

- Shares one push-style consumer (SPI transmitter MOSI bus or MIL transmitter push bus) between N push producers, using the request/done pulse handshake.
- Each input has a one-entry holding register. The block grants inputs round-robin, issues one downstream request per grant, and waits for the downstream done before routing a done pulse back to the owning input.
- It sits between status/command sources and a single transmitter inside the bridge top level.

---
 rtl/push_rr_arbiter_if.sv | 48 ++++
 rtl/push_rr_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/push_rr_arbiter_if.sv
// Push request/done bundle between N producers, the arbiter and one consumer.
// master = arbiter side, slave = producers plus downstream transmitter.
interface push_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int DATAW = 16
);
  localparam int IW = $clog2(N);

  logic [N-1:0]       in_request;
  logic [N*DATAW-1:0] in_data;
  logic [N-1:0]       in_done;
  logic [N-1:0]       in_busy;
  logic [N-1:0]       in_drop;
  logic [N-1:0]       in_err;
  logic               out_request;
  logic [DATAW-1:0]   out_data;
  logic               out_done;
  logic [IW-1:0]      grant_id;
  logic               active;

  modport master (
    input  in_request,
    input  in_data,
    input  out_done,
    output in_done,
    output in_busy,
    output in_drop,
    output in_err,
    output out_request,
    output out_data,
    output grant_id,
    output active
  );

  modport slave (
    output in_request,
    output in_data,
    output out_done,
    input  in_done,
    input  in_busy,
    input  in_drop,
    input  in_err,
    input  out_request,
    input  out_data,
    input  grant_id,
    input  active
  );
endinterface

// File: rtl/push_rr_arbiter.sv
// Round-robin share of one push consumer between N producers, one-entry hold each.
// Optional WAIT timeout abort enabled by defining PUSH_ARB_TIMEOUT_EN.
module push_rr_arbiter #(
  parameter int N       = 4,
  parameter int DATAW   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  push_rr_arbiter_if.master bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("push_rr_arbiter: parameter out of range");
  end

  state_t           state;
  logic [N-1:0]     pend;
  logic [DATAW-1:0] hold [N];
  logic [IW-1:0]    last;
  logic [IW-1:0]    gid;
  logic [IW-1:0]    nxt;
  logic             oreq;
  logic             act;
  logic [DATAW-1:0] odata;
  logic [N-1:0]     done_q;
  logic [N-1:0]     drop_q;

`ifdef PUSH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [N-1:0]  err_q;
  logic          tmo;

  assign tmo = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
`endif

  // Scan last+1, last+2, ... and keep the nearest pending slot.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N-1:0]  p,
    input logic [IW-1:0] l
  );
    int idx;
    rr_pick = l;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(l) + k) % N;
      if (p[idx]) rr_pick = idx[IW-1:0];
    end
  endfunction

  assign nxt = rr_pick(pend, last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      last   <= IW'(N - 1);
      gid    <= '0;
      oreq   <= 1'b0;
      act    <= 1'b0;
      odata  <= '0;
      done_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < N; i++) hold[i] <= '0;
`ifdef PUSH_ARB_TIMEOUT_EN
      cnt    <= '0;
      err_q  <= '0;
`endif
    end else begin
      done_q <= '0;
      drop_q <= '0;
`ifdef PUSH_ARB_TIMEOUT_EN
      err_q  <= '0;
`endif
      // A full slot rejects; a granted slot stays full until its done.
      for (int i = 0; i < N; i++) begin
        if (bus.in_request[i]) begin
          if (pend[i]) begin
            drop_q[i] <= 1'b1;
          end else begin
            pend[i] <= 1'b1;
            hold[i] <= bus.in_data[i*DATAW +: DATAW];
          end
        end
      end

      unique case (state)
        IDLE: begin
          if (|pend) begin
            gid   <= nxt;
            last  <= nxt;
            odata <= hold[nxt];
            oreq  <= 1'b1;
            act   <= 1'b1;
            state <= ISSUE;
`ifdef PUSH_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        ISSUE, WAIT: begin
          oreq <= 1'b0;
          if (bus.out_done) begin
            pend[gid]   <= 1'b0;
            done_q[gid] <= 1'b1;
            act         <= 1'b0;
            state       <= IDLE;
          end
`ifdef PUSH_ARB_TIMEOUT_EN
          else if (tmo) begin
            pend[gid]   <= 1'b0;
            done_q[gid] <= 1'b1;
            err_q[gid]  <= 1'b1;
            act         <= 1'b0;
            state       <= IDLE;
          end
`endif
          else begin
            state <= WAIT;
          end
`ifdef PUSH_ARB_TIMEOUT_EN
          if (state == WAIT) cnt <= cnt + CW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_request = oreq;
  assign bus.out_data    = odata;
  assign bus.grant_id    = gid;
  assign bus.active      = act;
  assign bus.in_done     = done_q;
  assign bus.in_busy     = pend;
  assign bus.in_drop     = drop_q;
`ifdef PUSH_ARB_TIMEOUT_EN
  assign bus.in_err      = err_q;
`else
  assign bus.in_err      = '0;
`endif
endmodule
